// File: rtl/fxp8s_out_packer.sv
// Output packer for the fxp8s PE array. Takes one sign-magnitude byte per handshake,
// applies per-matrix ReLU, packs bytes into LANES-wide words and queues them in a small FIFO.
`timescale 1ns/1ps
module fxp8s_out_packer #(
   parameter int ROWS       = 2,
   parameter int COLS       = 2,
   parameter int LANES      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 en_out_data,
   output logic                 rdy_out_data,
   input  logic [7:0]           out_data,
   input  logic                 cfg_relu,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [8*LANES-1:0]   m_data,
   output logic [LANES-1:0]     m_keep,
   output logic                 m_last,
   output logic                 frame_done,
   output logic [7:0]           frame_cnt
);

   localparam int NE = ROWS * COLS;
   localparam int EW = (NE > 1) ? $clog2(NE) : 1;
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = 8 * LANES;
   localparam int FW = DW + LANES + 1;
   localparam logic [EW-1:0] ELEM_LAST = EW'(NE - 1);
   localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   // Sign-magnitude ReLU: every byte with the sign bit set, negative zero included, clamps to 0.
   function automatic logic [7:0] relu8(input logic [7:0] b, input logic en);
      return (en && b[7]) ? 8'h00 : b;
   endfunction

   logic              r_rdy;
   logic [EW-1:0]     r_elem;
   logic [LW-1:0]     r_lane;
   logic              r_relu_q;
   logic [DW-1:0]     r_pack;
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_frame_done;
   logic [7:0]        r_frame_cnt;
   logic [FW-1:0]     r_mem [FIFO_DEPTH];

   logic              w_accept;
   logic              w_relu;
   logic [7:0]        w_byte;
   logic              w_elem_last;
   logic              w_push;
   logic              w_pop;
   logic [DW-1:0]     w_word;
   logic [LANES-1:0]  w_keep;
   logic [CW-1:0]     w_count_nxt;
   logic [FW-1:0]     w_head;

   assign w_accept    = en_out_data & r_rdy;
   assign w_relu      = (r_elem == '0) ? cfg_relu : r_relu_q;
   assign w_byte      = relu8(out_data, w_relu);
   assign w_elem_last = (r_elem == ELEM_LAST);
   assign w_push      = w_accept & ((r_lane == LANE_LAST) | w_elem_last);
   assign w_pop       = m_valid & m_ready;

   always_comb begin
      w_word = r_pack;
      w_keep = '0;
      for (int k = 0; k < LANES; k++) begin
         if (LW'(k) == r_lane) w_word[8*k +: 8] = w_byte;
         w_keep[k] = (LW'(k) <= r_lane);
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Ready is registered from the next FIFO occupancy, so it never looks at en_out_data.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rdy        <= 1'b0;
         r_elem       <= '0;
         r_lane       <= '0;
         r_relu_q     <= 1'b0;
         r_pack       <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         r_rdy        <= (w_count_nxt < DEPTH_C);
         r_count      <= w_count_nxt;
         r_frame_done <= w_accept & w_elem_last;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_accept) begin
            if (r_elem == '0) r_relu_q <= cfg_relu;
            if (w_elem_last) begin
               r_elem      <= '0;
               r_frame_cnt <= r_frame_cnt + 1'b1;
            end else begin
               r_elem <= r_elem + 1'b1;
            end
            if (w_push) begin
               r_lane <= '0;
               r_pack <= '0;
            end else begin
               r_lane <= r_lane + 1'b1;
               r_pack <= w_word;
            end
         end
      end
   end

   // Each FIFO entry stores {last, keep, data}.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {w_elem_last, w_keep, w_word};
   end

   assign w_head       = r_mem[r_rd_ptr];
   assign m_valid      = (r_count != '0);
   assign m_data       = m_valid ? w_head[DW-1:0] : '0;
   assign m_keep       = m_valid ? w_head[DW +: LANES] : '0;
   assign m_last       = m_valid & w_head[FW-1];
   assign rdy_out_data = r_rdy;
   assign frame_done   = r_frame_done;
   assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_fxp8s_out_packer.sv
// Directed bench for fxp8s_out_packer: three instances cover 2x2/4-lane, 3x2/4-lane and 2x2/1-lane.
`timescale 1ns/1ps
module tb_fxp8s_out_packer;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic        a_en = 0, a_relu = 0, a_mr = 0;
   logic [7:0]  a_dat = 0;
   logic        a_rdy, a_mv, a_ml, a_fd;
   logic [31:0] a_md;
   logic [3:0]  a_mk;
   logic [7:0]  a_fc;

   logic        b_en = 0, b_relu = 0, b_mr = 0;
   logic [7:0]  b_dat = 0;
   logic        b_rdy, b_mv, b_ml, b_fd;
   logic [31:0] b_md;
   logic [3:0]  b_mk;
   logic [7:0]  b_fc;

   logic        c_en = 0, c_relu = 0, c_mr = 0;
   logic [7:0]  c_dat = 0;
   logic        c_rdy, c_mv, c_ml, c_fd;
   logic [7:0]  c_md;
   logic [0:0]  c_mk;
   logic [7:0]  c_fc;

   int checks = 0;
   int errors = 0;

   fxp8s_out_packer #(.ROWS(2), .COLS(2), .LANES(4), .FIFO_DEPTH(4)) u_a (
      .clk(clk), .rstn(rstn), .en_out_data(a_en), .rdy_out_data(a_rdy), .out_data(a_dat),
      .cfg_relu(a_relu), .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md), .m_keep(a_mk),
      .m_last(a_ml), .frame_done(a_fd), .frame_cnt(a_fc));

   fxp8s_out_packer #(.ROWS(3), .COLS(2), .LANES(4), .FIFO_DEPTH(4)) u_b (
      .clk(clk), .rstn(rstn), .en_out_data(b_en), .rdy_out_data(b_rdy), .out_data(b_dat),
      .cfg_relu(b_relu), .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md), .m_keep(b_mk),
      .m_last(b_ml), .frame_done(b_fd), .frame_cnt(b_fc));

   fxp8s_out_packer #(.ROWS(2), .COLS(2), .LANES(1), .FIFO_DEPTH(4)) u_c (
      .clk(clk), .rstn(rstn), .en_out_data(c_en), .rdy_out_data(c_rdy), .out_data(c_dat),
      .cfg_relu(c_relu), .m_valid(c_mv), .m_ready(c_mr), .m_data(c_md), .m_keep(c_mk),
      .m_last(c_ml), .frame_done(c_fd), .frame_cnt(c_fc));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic rdy_of(input int u);
      case (u)
         0:       return a_rdy;
         1:       return b_rdy;
         default: return c_rdy;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge right after the byte was accepted.
   task automatic send(input int u, input logic [7:0] b);
      int n;
      n = 0;
      case (u)
         0:       begin a_dat = b; a_en = 1'b1; end
         1:       begin b_dat = b; b_en = 1'b1; end
         default: begin c_dat = b; c_en = 1'b1; end
      endcase
      while (!rdy_of(u) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic chk_a_reset(input string tag);
      chk({tag, "_rdy"},  a_rdy, 0);
      chk({tag, "_mv"},   a_mv,  0);
      chk({tag, "_md"},   a_md,  0);
      chk({tag, "_mk"},   a_mk,  0);
      chk({tag, "_ml"},   a_ml,  0);
      chk({tag, "_fd"},   a_fd,  0);
      chk({tag, "_fc"},   a_fc,  0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      logic        took;
      int          acc;

      // Reset state
      repeat (3) @(negedge clk);
      chk_a_reset("rst");
      chk("rst_c_rdy", c_rdy, 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", a_rdy, 1);

      // Plain stream, no ReLU
      a_mr = 1; a_relu = 0;
      send(0, 8'h01); send(0, 8'h85); send(0, 8'h7F);
      chk("t1_nv_before_last", a_mv, 0);
      send(0, 8'h80);
      a_en = 0;
      chk("t1_mv", a_mv, 1);
      chk("t1_md", a_md, 32'h807F8501);
      chk("t1_mk", a_mk, 4'hF);
      chk("t1_ml", a_ml, 1);
      chk("t1_fd", a_fd, 1);
      chk("t1_fc", a_fc, 1);
      @(negedge clk);
      chk("t1_mv_drained", a_mv, 0);
      chk("t1_fd_pulse", a_fd, 0);

      // ReLU latched on element 0, toggled off afterwards
      a_relu = 1;
      send(0, 8'h01);
      a_relu = 0;
      send(0, 8'h85); send(0, 8'h7F); send(0, 8'h80);
      a_en = 0;
      chk("t2_mv", a_mv, 1);
      chk("t2_md", a_md, 32'h007F0001);
      chk("t2_fc", a_fc, 2);
      @(negedge clk);

      // 3x2 matrix: full word then partial last word
      b_mr = 1;
      send(1, 8'h11); send(1, 8'h12); send(1, 8'h13); send(1, 8'h14);
      chk("t3_w1_mv", b_mv, 1);
      chk("t3_w1_md", b_md, 32'h14131211);
      chk("t3_w1_mk", b_mk, 4'hF);
      chk("t3_w1_ml", b_ml, 0);
      send(1, 8'h15);
      chk("t3_mid_mv", b_mv, 0);
      send(1, 8'h16);
      b_en = 0;
      chk("t3_w2_mv", b_mv, 1);
      chk("t3_w2_md", b_md, 32'h00001615);
      chk("t3_w2_mk", b_mk, 4'h3);
      chk("t3_w2_ml", b_ml, 1);
      chk("t3_fd", b_fd, 1);
      chk("t3_fc", b_fc, 1);
      @(negedge clk);

      // Backpressure on 1-lane instance
      c_mr = 0; c_dat = 8'h21; c_en = 1; acc = 0;
      for (int i = 0; i < 12; i++) begin
         took = c_rdy;
         @(negedge clk);
         if (took) begin
            acc++;
            c_dat = 8'h21 + 8'(acc);
         end
      end
      c_en = 0;
      chk("t4_accepts", acc, 4);
      chk("t4_rdy_full", c_rdy, 0);
      chk("t4_mv", c_mv, 1);
      chk("t4_head", c_md, 32'h21);
      chk("t4_mk", c_mk, 1);
      repeat (3) @(negedge clk);
      chk("t4_head_stable", c_md, 32'h21);
      c_mr = 1;
      for (int k = 0; k < 4; k++) begin
         chk("t4_drain_mv", c_mv, 1);
         chk("t4_drain_md", c_md, 32'h21 + k);
         chk("t4_drain_ml", c_ml, (k == 3) ? 1 : 0);
         @(negedge clk);
      end
      chk("t4_empty", c_mv, 0);
      chk("t4_rdy_back", c_rdy, 1);
      chk("t4_fc", c_fc, 1);

      // 256 back-to-back matrices, frame_cnt wraps past 255
      a_mr = 1;
      for (int m = 0; m < 256; m++) begin
         for (int e = 0; e < 4; e++) begin
            w[8*e +: 8] = 8'((m * 4 + e) & 8'h7F);
            send(0, w[8*e +: 8]);
         end
         chk("t5_md", a_md, w);
         chk("t5_mk", a_mk, 4'hF);
         chk("t5_ml", a_ml, 1);
         chk("t5_fc", a_fc, 32'((m + 3) & 255));
      end
      a_en = 0;
      @(negedge clk);
      chk("t5_fc_final", a_fc, 2);

      // Reset mid-matrix with one word held in the FIFO
      a_mr = 0;
      send(0, 8'h41); send(0, 8'h42); send(0, 8'h43); send(0, 8'h44);
      send(0, 8'h45); send(0, 8'h46);
      a_en = 0;
      chk("t6_held", a_mv, 1);
      #2 rstn = 1'b0;
      #1 chk_a_reset("t6_async");
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      a_mr = 1;
      send(0, 8'h31); send(0, 8'h32); send(0, 8'h33); send(0, 8'h34);
      a_en = 0;
      chk("t6_mv", a_mv, 1);
      chk("t6_md", a_md, 32'h34333231);
      chk("t6_mk", a_mk, 4'hF);
      chk("t6_ml", a_ml, 1);
      chk("t6_fc", a_fc, 1);
      @(negedge clk);
      chk("t6_single_word", a_mv, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
